mem_io_responder: RTL

//  Memory-side responder for the CPU byte bus (mem_a/mem_dout/mem_din/mem_wr) and for
//  io_buffer_full: the partner of mem_ctrl on that bus.

---
 rtl/mem_io_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// Byte RAM plus a memory-mapped I/O block (UART tx FIFO/rx, cycle counter, program stop) on the CPU byte bus.
// Reads return data one cycle after the address; io_buffer_full is raised early so in-flight tx writes still fit.
module mem_io_responder #(
  parameter int RAM_AW      = 17,
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:0]       mem_a,
  input  logic [7:0]        mem_dout,
  input  logic              mem_wr,
  output logic [7:0]        mem_din,
  output logic              io_buffer_full,
  input  logic              ld_we,
  input  logic [RAM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output logic              prog_end,
  output logic              tx_overflow
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]        ram [2**RAM_AW];
  logic [7:0]        fifo_q [TX_DEPTH];

  logic [7:0]        ram_rd_q;
  logic              sel_ram_q;
  logic [7:0]        io_rd_q, io_rd_d;
  logic [31:0]       cnt_q;
  logic [23:0]       snap_q, snap_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q;
  logic              prog_end_q, prog_end_d;
  logic              ovf_q, ovf_d;

  logic              is_ram, is_io, io_rd, io_wr;
  logic [2:0]        sel;
  logic [RAM_AW-1:0] ram_addr;
  logic              cpu_ram_we;
  logic              push_req, push_ok, pop, fifo_full;
  logic [7:0]        push_dat;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^mem_a[31:18];

  assign is_ram     = ~mem_a[17];
  assign is_io      = (mem_a[17:16] == 2'b11);
  assign sel        = mem_a[2:0];
  assign io_rd      = is_io & ~mem_wr;
  assign io_wr      = is_io & mem_wr;
  assign ram_addr   = mem_a[RAM_AW-1:0];
  assign cpu_ram_we = is_ram & mem_wr;

  // Single write port: a loader write always wins over a CPU write in the same cycle.
  always_ff @(posedge clk_in) begin
    if (ld_we) begin
      ram[ld_addr] <= ld_data;
    end else if (cpu_ram_we) begin
      ram[ram_addr] <= mem_dout;
    end
    ram_rd_q <= ram[ram_addr];
  end

  always_comb begin
    io_rd_d = 8'h00;
    snap_d  = snap_q;
    rx_pop  = 1'b0;
    if (io_rd && !rst_in) begin
      case (sel)
        3'd0: begin
          if (rx_valid) begin
            io_rd_d = rx_data;
            rx_pop  = 1'b1;
          end
        end
        3'd4: begin
          io_rd_d = cnt_q[7:0];
          snap_d  = cnt_q[31:8];
        end
        3'd5:    io_rd_d = snap_q[7:0];
        3'd6:    io_rd_d = snap_q[15:8];
        3'd7:    io_rd_d = snap_q[23:16];
        default: io_rd_d = 8'h00;
      endcase
    end
  end

  assign fifo_full = (count_q == CW'(TX_DEPTH));
  assign pop       = (count_q != '0) & tx_ready;
  assign push_req  = io_wr & (((sel == 3'd0) && (mem_dout != 8'h00)) || (sel == 3'd4));
  assign push_dat  = (sel == 3'd4) ? 8'h00 : mem_dout;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok   = push_req & (~fifo_full | pop);
  assign count_d   = count_q + CW'(push_ok) - CW'(pop);

  assign prog_end_d = prog_end_q | (io_wr & (sel == 3'd4));
  assign ovf_d      = ovf_q | (push_req & ~push_ok);

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= push_dat;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_ram_q  <= 1'b0;
      io_rd_q    <= 8'h00;
      cnt_q      <= 32'h0;
      snap_q     <= 24'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      prog_end_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sel_ram_q  <= is_ram & ~mem_wr;
      io_rd_q    <= io_rd_d;
      cnt_q      <= cnt_q + 32'd1;
      snap_q     <= snap_d;
      wr_ptr_q   <= wr_ptr_q + PW'(push_ok);
      rd_ptr_q   <= rd_ptr_q + PW'(pop);
      count_q    <= count_d;
      full_q     <= (count_d >= CW'(TX_DEPTH - FULL_MARGIN));
      prog_end_q <= prog_end_d;
      ovf_q      <= ovf_d;
    end
  end

  assign mem_din        = sel_ram_q ? ram_rd_q : io_rd_q;
  assign io_buffer_full = full_q;
  assign tx_valid       = (count_q != '0);
  assign tx_data        = fifo_q[rd_ptr_q];
  assign prog_end       = prog_end_q;
  assign tx_overflow    = ovf_q;

endmodule
